warp_fetcher: RTL and testbench

WARP_FETCHER -- requirements
Module: warp_fetcher

---
 rtl/warp_fetcher.sv | 135 +++++++++++++
 tb/tb_warp_fetcher.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : warp_fetcher
// Description : Per-warp single-entry instruction buffer in front of program
//               memory. A hit on the buffered PC returns the stored
//               instruction one cycle after acceptance; a miss reads program
//               memory, refills the warp's entry and returns the data.
// Ports       : clk, reset              - clock / synchronous active-high reset
//               fetch_req, warp_id, pc  - scheduler request (held until ready)
//               flush                   - invalidate every buffer entry
//               mem_read_*              - program memory read channel
//               instruction_ready       - one-cycle pulse, instruction valid
//               instruction             - fetched instruction (held stable)
//               fetch_state             - current FSM state
//               hit_count               - saturating buffer-hit counter
// Revision    : 1.0 - initial release
// ============================================================================
module warp_fetcher #(
    parameter int MAX_WARPS_PER_CORE = 2,
    parameter int WARP_ID_BITS       = $clog2(MAX_WARPS_PER_CORE),
    parameter int PROGRAM_ADDR_BITS  = 8,
    parameter int PROGRAM_DATA_BITS  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_req,
    input  logic [WARP_ID_BITS-1:0]      warp_id,
    input  logic [PROGRAM_ADDR_BITS-1:0] pc,
    input  logic                         flush,
    output logic                         mem_read_valid,
    output logic [PROGRAM_ADDR_BITS-1:0] mem_read_address,
    input  logic                         mem_read_ready,
    input  logic [PROGRAM_DATA_BITS-1:0] mem_read_data,
    output logic                         instruction_ready,
    output logic [PROGRAM_DATA_BITS-1:0] instruction,
    output logic [1:0]                   fetch_state,
    output logic [15:0]                  hit_count
);

    localparam logic [1:0] c_IDLE     = 2'b00;
    localparam logic [1:0] c_FETCHING = 2'b01;
    localparam logic [1:0] c_DONE     = 2'b10;

    logic [1:0]                   r_state;
    logic [WARP_ID_BITS-1:0]      r_warp;
    logic [PROGRAM_ADDR_BITS-1:0] r_pc;
    logic [PROGRAM_DATA_BITS-1:0] r_instruction;
    logic [15:0]                  r_hit_count;

    logic [MAX_WARPS_PER_CORE-1:0] r_valid;
    logic [PROGRAM_ADDR_BITS-1:0]  r_tag  [MAX_WARPS_PER_CORE];
    logic [PROGRAM_DATA_BITS-1:0]  r_data [MAX_WARPS_PER_CORE];

    logic                         w_hit;
    logic [PROGRAM_DATA_BITS-1:0] w_entry_data;
    logic                         w_hit_accept;

    // Lookup by scanning the implemented entries only: a warp_id at or
    // beyond MAX_WARPS_PER_CORE matches nothing and therefore misses.
    always_comb begin
        w_hit        = 1'b0;
        w_entry_data = '0;
        for (int i = 0; i < MAX_WARPS_PER_CORE; i++) begin
            if ((warp_id == WARP_ID_BITS'(i)) && r_valid[i] && (r_tag[i] == pc)) begin
                w_hit        = 1'b1;
                w_entry_data = r_data[i];
            end
        end
    end

    // A flush in the acceptance cycle forces the request down the miss path.
    assign w_hit_accept = (r_state == c_IDLE) && fetch_req && w_hit && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_warp        <= '0;
            r_pc          <= '0;
            r_instruction <= '0;
            r_hit_count   <= '0;
            r_valid       <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (fetch_req) begin
                        r_warp <= warp_id;
                        r_pc   <= pc;
                        if (w_hit_accept) begin
                            r_instruction <= w_entry_data;
                            if (r_hit_count != 16'hFFFF) begin
                                r_hit_count <= r_hit_count + 16'd1;
                            end
                            r_state <= c_DONE;
                        end else begin
                            r_state <= c_FETCHING;
                        end
                    end
                end
                c_FETCHING: begin
                    if (mem_read_ready) begin
                        r_instruction <= mem_read_data;
                        for (int i = 0; i < MAX_WARPS_PER_CORE; i++) begin
                            if (r_warp == WARP_ID_BITS'(i)) begin
                                r_valid[i] <= 1'b1;
                                r_tag[i]   <= r_pc;
                                r_data[i]  <= mem_read_data;
                            end
                        end
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            // Placed after the fill so a coincident flush leaves the entry invalid.
            if (flush) begin
                r_valid <= '0;
            end
        end
    end

    assign mem_read_valid    = (r_state == c_FETCHING);
    assign mem_read_address  = (r_state == c_FETCHING) ? r_pc : '0;
    assign instruction_ready = (r_state == c_DONE);
    assign instruction       = r_instruction;
    assign fetch_state       = r_state;
    assign hit_count         = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_warp_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_warp_fetcher
// Description : Scoreboard bench for warp_fetcher. A reference buffer model
//               predicts each fetch result; a monitor pops and compares on
//               every instruction_ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_warp_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [0:0]  warp_id;
    logic [7:0]  pc;
    logic        flush_drv;
    logic        flush_rsp;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic        instruction_ready;
    logic [15:0] instruction;
    logic [1:0]  fetch_state;
    logic [15:0] hit_count;

    warp_fetcher dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_req         (fetch_req),
        .warp_id           (warp_id),
        .pc                (pc),
        .flush             (flush_drv | flush_rsp),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .instruction_ready (instruction_ready),
        .instruction       (instruction),
        .fetch_state       (fetch_state),
        .hit_count         (hit_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit abort = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program memory contents and reference buffer model
    logic [15:0] mem [256];
    bit          m_valid [2];
    logic [7:0]  m_tag   [2];
    logic [15:0] m_data  [2];
    int          m_hits;

    typedef struct {
        logic [15:0] instr;
        bit          hit;
        logic [7:0]  pc;
        int          hits;
    } item_t;
    item_t sb[$];

    // Responder controls
    bit rsp_en        = 1;
    int rsp_lat_fixed = -1;
    bit flush_on_fill = 0;

    // Memory responder
    initial begin
        int wait_cnt;
        int lat_target;
        wait_cnt       = 0;
        lat_target     = 0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        flush_rsp      = 1'b0;
        forever begin
            @(negedge clk);
            mem_read_ready = 1'b0;
            flush_rsp      = 1'b0;
            if (mem_read_valid && rsp_en) begin
                if (wait_cnt >= lat_target) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = mem[mem_read_address];
                    flush_rsp      = flush_on_fill;
                    wait_cnt       = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt   = 0;
                lat_target = (rsp_lat_fixed >= 0) ? rsp_lat_fixed : int'($urandom_range(0, 3));
            end
        end
    end

    // Monitor
    initial begin
        bit          mem_seen;
        logic [15:0] last_instr;
        item_t       it;
        mem_seen   = 0;
        last_instr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mem_seen   = 0;
                last_instr = '0;
            end else begin
                if (mem_read_valid) begin
                    mem_seen = 1;
                    if (sb.size() > 0) check("mem_addr", 32'(mem_read_address), 32'(sb[0].pc));
                end
                if (instruction_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_ready", 32'(instruction_ready), 32'd0);
                    end else begin
                        it = sb.pop_front();
                        check("instruction", 32'(instruction), 32'(it.instr));
                        check("went_to_mem", 32'(mem_seen), 32'(!it.hit));
                        check("hit_count", 32'(hit_count), 32'(it.hits));
                        check("state_done", 32'(fetch_state), 32'd2);
                    end
                    last_instr = instruction;
                    mem_seen   = 0;
                end else begin
                    check("instr_hold", 32'(instruction), 32'(last_instr));
                end
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 2; i++) m_valid[i] = 0;
    endtask

    task automatic do_req(input int w, input logic [7:0] p, input bit fl_req, input bit fl_fill);
        item_t it;
        bit    hit;
        int    n;
        if (abort) return;
        hit = !fl_req && m_valid[w] && (m_tag[w] == p);
        if (fl_req) model_clear();
        if (hit) begin
            it.instr = m_data[w];
            if (m_hits < 65535) m_hits++;
        end else begin
            it.instr = mem[p];
            if (fl_fill) begin
                model_clear();
            end else begin
                m_valid[w] = 1;
                m_tag[w]   = p;
                m_data[w]  = mem[p];
            end
        end
        it.hit  = hit;
        it.pc   = p;
        it.hits = m_hits;
        sb.push_back(it);
        @(negedge clk);
        flush_on_fill = fl_fill;
        fetch_req     = 1'b1;
        warp_id       = 1'(w);
        pc            = p;
        flush_drv     = fl_req;
        n = 0;
        do begin
            @(negedge clk);
            flush_drv = 1'b0;
            n++;
        end while (!instruction_ready && n < 64);
        fetch_req     = 1'b0;
        flush_on_fill = 0;
        if (!instruction_ready) begin
            check("ready_timeout", 32'(n), 32'd0);
            abort = 1;
        end
    endtask

    task automatic idle_flush();
        @(negedge clk);
        flush_drv = 1'b1;
        @(negedge clk);
        flush_drv = 1'b0;
        model_clear();
    endtask

    initial begin
        reset     = 1'b1;
        fetch_req = 1'b0;
        warp_id   = '0;
        pc        = '0;
        flush_drv = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        model_clear();
        m_hits = 0;

        repeat (3) @(negedge clk);
        check("rst_mem_valid", 32'(mem_read_valid), 32'd0);
        check("rst_mem_addr", 32'(mem_read_address), 32'd0);
        check("rst_ready", 32'(instruction_ready), 32'd0);
        check("rst_instruction", 32'(instruction), 32'd0);
        check("rst_hit_count", 32'(hit_count), 32'd0);
        check("rst_state", 32'(fetch_state), 32'd0);
        reset = 1'b0;

        // Cold miss, memory answers after 3 cycles
        mem[8'h05]    = 16'hA1B2;
        rsp_lat_fixed = 3;
        do_req(0, 8'h05, 0, 0);
        rsp_lat_fixed = -1;
        // Hit on the same warp/pc
        do_req(0, 8'h05, 0, 0);
        // Per-warp isolation and tag mismatch
        do_req(1, 8'h05, 0, 0);
        do_req(0, 8'h06, 0, 0);
        do_req(1, 8'h05, 0, 0);
        // Flush while idle, then the request misses
        idle_flush();
        do_req(0, 8'h05, 0, 0);
        // Flush coincident with the request forces a miss
        do_req(0, 8'h05, 1, 0);
        do_req(0, 8'h05, 0, 0);
        // Flush coincident with the fill: data delivered, entry stays invalid
        do_req(1, 8'h09, 0, 1);
        do_req(1, 8'h09, 0, 0);
        do_req(1, 8'h09, 0, 0);

        // Randomized traffic, with memory contents changing under the buffer
        for (int k = 0; k < 400 && !abort; k++) begin
            if ($urandom_range(0, 4) == 0) mem[8'($urandom_range(5, 8))] = 16'($urandom);
            if ($urandom_range(0, 14) == 0) idle_flush();
            do_req(int'($urandom_range(0, 1)), 8'($urandom_range(5, 8)),
                   ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        // Saturation: preload the counter near its ceiling, then keep hitting
        if (!abort) begin
            do_req(0, 8'h07, 0, 0);
            @(negedge clk);
            force dut.r_hit_count = 16'hFFFD;
            @(negedge clk);
            release dut.r_hit_count;
            m_hits = 16'hFFFD;
            for (int k = 0; k < 5; k++) do_req(0, 8'h07, 0, 0);
            @(negedge clk);
            check("hit_saturated", 32'(hit_count), 32'h0000FFFF);
        end

        // Reset while fetching: request dropped, no pulse, counters cleared
        if (!abort) begin
            rsp_en = 0;
            @(negedge clk);
            fetch_req = 1'b1;
            warp_id   = 1'b0;
            pc        = 8'h30;
            repeat (2) @(negedge clk);
            check("pre_rst_fetching", 32'(mem_read_valid), 32'd1);
            reset     = 1'b1;
            fetch_req = 1'b0;
            @(negedge clk);
            check("midrst_mem_valid", 32'(mem_read_valid), 32'd0);
            check("midrst_state", 32'(fetch_state), 32'd0);
            check("midrst_hit_count", 32'(hit_count), 32'd0);
            check("midrst_ready", 32'(instruction_ready), 32'd0);
            @(negedge clk);
            reset  = 1'b0;
            rsp_en = 1;
            model_clear();
            m_hits = 0;
            repeat (4) @(negedge clk);
            check("post_rst_ready", 32'(instruction_ready), 32'd0);
            do_req(1, 8'h05, 0, 0);
            do_req(1, 8'h05, 0, 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
